div16s8s_seq: RTL



---
 rtl/div16s8s_seq_pkg.sv | 16 +
 rtl/div16s8s_seq_if.sv | 26 ++
 rtl/div16s8s_seq_restore_step.sv | 21 ++
 rtl/div16s8s_seq.sv | 125 ++++++++++++
 4 files changed

// File: rtl/div16s8s_seq_pkg.sv
// Shared types and sizing for the sequential signed divider.
// Widths, the FSM state encoding and the step-counter width live here.
package div_pkg;

    localparam int DIVIDEND_W = 16;
    localparam int DIVISOR_W  = 8;
    localparam int CNT_W      = $clog2(DIVIDEND_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage : div_pkg

// File: rtl/div16s8s_seq_if.sv
// Operand/result handshake bundle for div16s8s_seq.
// The master drives operands and out_ready; the slave is the divider.
interface div16s8s_seq_if;

    logic                            in_valid;
    logic                            in_ready;
    logic [div_pkg::DIVIDEND_W-1:0]  A;
    logic [div_pkg::DIVISOR_W-1:0]   B;
    logic                            out_valid;
    logic                            out_ready;
    logic [div_pkg::DIVIDEND_W-1:0]  Q;
    logic [div_pkg::DIVISOR_W-1:0]   R;
    logic                            dbz;
    logic                            ovf;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, Q, R, dbz, ovf
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, Q, R, dbz, ovf
    );

endinterface : div16s8s_seq_if

// File: rtl/div16s8s_seq_restore_step.sv
// One radix-2 restoring step on unsigned magnitudes: shift in the next
// dividend bit, trial-subtract the divisor, restore if it went negative.
module div_restore_step #(
    parameter int W = 8
) (
    input  logic [W:0]   i_prem,
    input  logic         i_bit,
    input  logic [W-1:0] i_bmag,
    output logic [W:0]   o_prem,
    output logic         o_qbit
);

    logic [W+1:0] w_shift;
    logic [W:0]   w_diff;

    assign w_shift = {i_prem, i_bit};
    assign o_qbit  = (w_shift >= {2'b00, i_bmag});
    assign w_diff  = w_shift[W:0] - {1'b0, i_bmag};
    assign o_prem  = o_qbit ? w_diff : w_shift[W:0];

endmodule : div_restore_step

// File: rtl/div16s8s_seq.sv
// Sequential truncating signed divider, 16b / 8b, one quotient bit per clock.
// Works on magnitudes and re-applies the signs in a single fix-up cycle.
module div16s8s_seq
    import div_pkg::*;
(
    input  logic                 clock,
    input  logic                 rst_n,
    div16s8s_seq_if.slave        bus
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIVIDEND_W - 1);

    state_t                 r_state;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic                   r_sign_a;
    logic                   r_sign_b;
    logic                   r_ovf_pend;
    logic [DIVIDEND_W-1:0]  r_dvd;
    logic [DIVISOR_W:0]     r_prem;
    logic [DIVISOR_W-1:0]   r_bmag;
    logic [CNT_W-1:0]       r_count;
    logic [DIVIDEND_W-1:0]  r_q;
    logic [DIVISOR_W-1:0]   r_r;
    logic                   r_dbz;
    logic                   r_ovf;

    logic [DIVIDEND_W-1:0]  w_amag;
    logic [DIVISOR_W-1:0]   w_bmag;
    logic                   w_b_zero;
    logic [DIVISOR_W:0]     w_prem_nxt;
    logic                   w_qbit;

    // Magnitudes stay unsigned so |-32768| and |-128| fit without a sign bit.
    assign w_amag   = bus.A[DIVIDEND_W-1] ? -bus.A : bus.A;
    assign w_bmag   = bus.B[DIVISOR_W-1]  ? -bus.B : bus.B;
    assign w_b_zero = (bus.B == '0);

    div_restore_step #(.W(DIVISOR_W)) u_step (
        .i_prem (r_prem),
        .i_bit  (r_dvd[DIVIDEND_W-1]),
        .i_bmag (r_bmag),
        .o_prem (w_prem_nxt),
        .o_qbit (w_qbit)
    );

    // NOTE: datapath registers are reset too, so Q/R read zero during reset.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_sign_a    <= 1'b0;
            r_sign_b    <= 1'b0;
            r_ovf_pend  <= 1'b0;
            r_dvd       <= '0;
            r_prem      <= '0;
            r_bmag      <= '0;
            r_count     <= '0;
            r_q         <= '0;
            r_r         <= '0;
            r_dbz       <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            // NOTE: non-blocking everywhere here; every read sees pre-edge state.
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_sign_a   <= bus.A[DIVIDEND_W-1];
                        r_sign_b   <= bus.B[DIVISOR_W-1];
                        r_dvd      <= w_amag;
                        r_bmag     <= w_bmag;
                        r_prem     <= '0;
                        r_count    <= '0;
                        r_ovf_pend <= (bus.A == {1'b1, {(DIVIDEND_W-1){1'b0}}}) &&
                                      (bus.B == '1);
                        r_in_ready <= 1'b0;
                        r_dbz      <= w_b_zero;
                        r_ovf      <= 1'b0;
                        if (w_b_zero) begin
                            r_q     <= '0;
                            r_r     <= bus.A[DIVISOR_W-1:0];
                            r_state <= DONE;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_prem  <= w_prem_nxt;
                    r_dvd   <= {r_dvd[DIVIDEND_W-2:0], w_qbit};
                    r_count <= r_count + 1'b1;
                    if (r_count == LAST_STEP) r_state <= FIX;
                end
                FIX: begin
                    r_q         <= (r_sign_a ^ r_sign_b) ? -r_dvd : r_dvd;
                    r_r         <= r_sign_a ? -r_prem[DIVISOR_W-1:0]
                                            : r_prem[DIVISOR_W-1:0];
                    r_ovf       <= r_ovf_pend;
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    // The divide-by-zero path arrives here with out_valid still low.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.Q         = r_q;
    assign bus.R         = r_r;
    assign bus.dbz       = r_dbz;
    assign bus.ovf       = r_ovf;

endmodule : div16s8s_seq
